// File: rtl/aes_dec_pkg.sv
// Package: aes_dec_pkg
// FSM state encoding, AES round-count constants and GF(2^8) helpers shared by
// the inverse-cipher controller and its round datapath.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_t;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam logic [7:0] GF_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box computed rather than tabulated: undo the affine map, then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte k lives at [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Module: aes_inv_round
// Combinational single inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;

    // Row rotation followed by per-byte inverse substitution
    always_comb begin
        shifted = inv_shift_rows(state_in);
        subbed  = '0;
        for (int k = 0; k < 16; k++) begin
            subbed[127-8*k -: 8] = inv_sbox(shifted[127-8*k -: 8]);
        end
    end

    assign keyed     = subbed ^ rk;
    assign state_out = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Module: aes_dec_round_ctrl
// Iterative AES inverse-cipher sequencer, one block in flight.
// Optional feature macro: AES_DEC_FLUSH_EN adds a synchronous 'flush' abort input.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for ciphertext; key NR requested for initial whitening
// ST_ROUND | full inverse round using key 'round', counting down to 1
// ST_FINAL | last round (no InvMixColumns) with key 0
// ST_DONE  | plaintext held on out_data until consumed
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef AES_DEC_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy
);

    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256) || (NR >= (1 << KIDX_W))) begin : g_bad_nr
        $error("aes_dec_round_ctrl: NR must be 10, 12 or 14 and fit in KIDX_W bits");
    end

    dec_state_t        state;
    logic [KIDX_W-1:0] round;
    logic [127:0]      state_reg;
    logic [127:0]      round_out;
    logic              accept;
    logic              flush_now;

`ifdef AES_DEC_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // DONE with out_ready accepts the next block on the same edge, so there is no bubble
    assign in_ready = ((state == ST_IDLE) || ((state == ST_DONE) && out_ready)) && !flush_now;
    assign accept   = in_valid && in_ready;
    assign out_data = state_reg;

    // Key index for whichever state consumes rk_data this cycle; DONE asks for NR
    // so that a same-edge accept gets the whitening key
    always_comb begin
        rk_idx = KIDX_W'(NR);
        case (state)
            ST_ROUND: rk_idx = round;
            ST_FINAL: rk_idx = '0;
            default:  rk_idx = KIDX_W'(NR);
        endcase
    end

    aes_inv_round u_round (
        .state_in  (state_reg),
        .rk        (rk_data),
        .last      (state == ST_FINAL),
        .state_out (round_out)
    );

    // Sequencer: state, round counter, datapath register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            round     <= '0;
            state_reg <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush_now) begin
            state     <= ST_IDLE;
            round     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= in_data ^ rk_data;
                        round     <= KIDX_W'(NR - 1);
                        state     <= ST_ROUND;
                        busy      <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    round     <= round - KIDX_W'(1);
                    if (round == KIDX_W'(1)) state <= ST_FINAL;
                end
                ST_FINAL: begin
                    state_reg <= round_out;
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            state_reg <= in_data ^ rk_data;
                            round     <= KIDX_W'(NR - 1);
                            state     <= ST_ROUND;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Testbench: tb_aes_dec_round_ctrl
// Drives an AES-128 instance and an AES-256 instance of aes_dec_round_ctrl.
// Ciphertexts come from a forward AES model; the DUT must recover the plaintext.
// Flush scenarios are compiled in when AES_DEC_FLUSH_EN is defined.
module tb_aes_dec_round_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic         in_ready_a, out_valid_a, busy_a;
    logic [127:0] in_data_a = '0;
    logic [127:0] rk_data_a, out_data_a;
    logic [3:0]   rk_idx_a;

    logic         in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [127:0] in_data_b = '0;
    logic [127:0] rk_data_b, out_data_b;
    logic [3:0]   rk_idx_b;

`ifdef AES_DEC_FLUSH_EN
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
`endif

    logic [127:0] rk_a [0:15];
    logic [127:0] rk_b [0:15];
    assign rk_data_a = rk_a[rk_idx_a];
    assign rk_data_b = rk_b[rk_idx_b];

    aes_dec_round_ctrl #(.NR(10), .KIDX_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_DEC_FLUSH_EN
        .flush(flush_a),
`endif
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .rk_idx(rk_idx_a), .rk_data(rk_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .busy(busy_a)
    );

    aes_dec_round_ctrl #(.NR(14), .KIDX_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_DEC_FLUSH_EN
        .flush(flush_b),
`endif
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .rk_idx(rk_idx_b), .rk_data(rk_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .busy(busy_b)
    );

    int nchk  = 0;
    int npass = 0;
    int cyc   = 0;

    // ---------------- forward AES reference model ----------------
    logic [7:0]   sbox [0:255];
    logic [127:0] ks   [0:15];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Walk generator 3 and its inverse to fill the forward S-box
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ks[0][127-8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                s = t;
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[r][127-8*k -: 8];
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_keys(input int sel, input int nr);
        for (int r = 0; r < 16; r++) begin
            if (sel != 0) rk_b[r] = (r <= nr) ? ks[r] : '0;
            else          rk_a[r] = (r <= nr) ? ks[r] : '0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Send one block, verify key sequence, latency, plaintext, random backpressure and drain
    task automatic run_block(input int sel, input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int         nr, lat, hold;
        logic [3:0] seq [$];
        nr = (sel != 0) ? 14 : 10;
        seq.delete();
        if (sel != 0) begin in_data_b = ct; in_valid_b = 1'b1; end
        else          begin in_data_a = ct; in_valid_a = 1'b1; end
        #1;
        check({tag, "_in_ready"}, (sel != 0) ? in_ready_b : in_ready_a, 1'b1);
        seq.push_back((sel != 0) ? rk_idx_b : rk_idx_a);
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 0;
        while (!((sel != 0) ? out_valid_b : out_valid_a) && lat < 40) begin
            seq.push_back((sel != 0) ? rk_idx_b : rk_idx_a);
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, nr);
        check({tag, "_data"}, (sel != 0) ? out_data_b : out_data_a, pt);
        check({tag, "_nkeys"}, seq.size(), nr + 1);
        for (int i = 0; i < seq.size() && i <= nr; i++)
            check({tag, "_rk_idx"}, seq[i], nr - i);
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_data"}, (sel != 0) ? out_data_b : out_data_a, pt);
            check({tag, "_hold_valid"}, (sel != 0) ? out_valid_b : out_valid_a, 1'b1);
        end
        if (sel != 0) out_ready_b = 1'b1; else out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        #1;
        check({tag, "_drain_valid"}, (sel != 0) ? out_valid_b : out_valid_a, 1'b0);
        check({tag, "_drain_busy"}, (sel != 0) ? busy_b : busy_a, 1'b0);
        check({tag, "_drain_in_ready"}, (sel != 0) ? in_ready_b : in_ready_a, 1'b1);
    endtask

    // Runaway guard in case a handshake never completes
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt, ct, pt2, ct2;
        int           lat, hs;

        build_sbox();
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        load_keys(0, 10);
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        load_keys(1, 14);

        repeat (3) tick();
        check("rst_hold_out_valid", out_valid_a, 1'b0);
        check("rst_hold_busy", busy_a, 1'b0);
        check("rst_hold_in_ready", in_ready_a, 1'b1);
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_in_ready", in_ready_a, 1'b1);
        check("rst_out_data", out_data_a, 128'h0);
        check("rst_rk_idx_a", rk_idx_a, 4'd10);
        check("rst_rk_idx_b", rk_idx_b, 4'd14);

        // FIPS-197 C.1 and C.3
        run_block(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, "c1");
        run_block(1, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, "c3");

        // Random keys and blocks, AES-128
        repeat (4) begin
            expand_key({rand128(), 128'h0}, 4, 10);
            load_keys(0, 10);
            pt = rand128();
            run_block(0, encrypt(pt, 10), pt, "rnd128");
        end
        // Random keys and blocks, AES-256
        repeat (2) begin
            expand_key({rand128(), rand128()}, 8, 14);
            load_keys(1, 14);
            pt = rand128();
            run_block(1, encrypt(pt, 14), pt, "rnd256");
        end

        // Backpressure: five cycles held in DONE, then exactly one handshake
        expand_key({rand128(), 128'h0}, 4, 10);
        load_keys(0, 10);
        pt = rand128();
        ct = encrypt(pt, 10);
        in_data_a = ct; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 40) begin tick(); lat++; end
        check("bp_latency", lat, 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data", out_data_a, pt);
            check("bp_in_ready", in_ready_a, 1'b0);
            check("bp_busy", busy_a, 1'b1);
            check("bp_valid", out_valid_a, 1'b1);
        end
        out_ready_a = 1'b1;
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid_a && out_ready_a) hs++;
            tick();
        end
        out_ready_a = 1'b0;
        check("bp_handshakes", hs, 1);

        // Back-to-back: second block offered through ROUND, taken on the first's output edge
        pt  = rand128(); ct  = encrypt(pt, 10);
        pt2 = rand128(); ct2 = encrypt(pt2, 10);
        in_data_a = ct; in_valid_a = 1'b1;
        tick();
        in_data_a = ct2;
        out_ready_a = 1'b1;
        #1;
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            check("b2b_ignored_in_ready", in_ready_a, 1'b0);
            tick();
            lat++;
        end
        check("b2b_lat1", lat, 10);
        check("b2b_data1", out_data_a, pt);
        check("b2b_in_ready_done", in_ready_a, 1'b1);
        tick();
        in_valid_a = 1'b0;
        check("b2b_accepted_busy", busy_a, 1'b1);
        check("b2b_valid_dropped", out_valid_a, 1'b0);
        lat = 1;
        while (!out_valid_a && lat < 40) begin tick(); lat++; end
        check("b2b_gap", lat, 11);
        check("b2b_data2", out_data_a, pt2);
        tick();
        out_ready_a = 1'b0;
        check("b2b_end_busy", busy_a, 1'b0);

        // Async reset mid-block at round 5
        pt = rand128(); ct = encrypt(pt, 10);
        in_data_a = ct; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        lat = 0;
        while (rk_idx_a != 4'd5 && lat < 40) begin tick(); lat++; end
        check("mid_rst_round5", rk_idx_a, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid_a, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_in_ready", in_ready_a, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_output", out_valid_a, 1'b0);
        pt = rand128();
        run_block(0, encrypt(pt, 10), pt, "post_rst");

`ifdef AES_DEC_FLUSH_EN
        // Flush during FINAL: no output, IDLE next cycle
        pt = rand128(); ct = encrypt(pt, 10);
        in_data_a = ct; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        lat = 0;
        while (rk_idx_a != 4'd0 && lat < 40) begin tick(); lat++; end
        check("fl_final_reached", rk_idx_a, 4'd0);
        flush_a = 1'b1;
        #1;
        check("fl_in_ready", in_ready_a, 1'b0);
        tick();
        flush_a = 1'b0;
        #1;
        check("fl_idle_busy", busy_a, 1'b0);
        check("fl_idle_in_ready", in_ready_a, 1'b1);
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_a) hs++;
            tick();
        end
        check("fl_no_output", hs, 0);

        // Flush beats a simultaneous accept
        in_data_a = ct; in_valid_a = 1'b1; flush_a = 1'b1;
        #1;
        check("fl_acc_in_ready", in_ready_a, 1'b0);
        tick();
        in_valid_a = 1'b0; flush_a = 1'b0;
        #1;
        check("fl_acc_busy", busy_a, 1'b0);
        check("fl_acc_rk_idx", rk_idx_a, 4'd10);
        pt = rand128();
        run_block(0, encrypt(pt, 10), pt, "post_flush");
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
